// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART transmitter among N_REQ clients.
//   Each transfer: grant the next requester after the previous owner, latch its
//   payload onto DataIn, hold NewData for NEWDATA_CYCLES clocks, wait for a
//   fresh rising edge on DoneTx (or abort after TIMEOUT_CYCLES), then keep the
//   transmitter idle for GAP_CYCLES clocks before arbitrating again.
// Ports
//   CLK_Baudin : clock, all logic on the rising edge
//   RstTx      : synchronous active-high reset
//   Req        : level request per requester
//   ReqData    : payloads, requester i at [i*DATA_W +: DATA_W]
//   Gnt        : one-hot current owner, LOAD entry until release
//   Ack        : one-clock pulse to the owner on a completed transfer
//   Err        : one-clock pulse on a watchdog abort
//   Busy       : high whenever the scheduler is not idle
//   DataIn     : payload to the transmitter, stable from grant until release
//   NewData    : start strobe to the transmitter
//   DoneTx     : transmitter done level, only rising edges count
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NEWDATA_CYCLES = 50,
    parameter int unsigned GAP_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      CLK_Baudin,
    input  logic                      RstTx,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ*DATA_W-1:0]   ReqData,
    output logic [N_REQ-1:0]          Gnt,
    output logic [N_REQ-1:0]          Ack,
    output logic                      Err,
    output logic                      Busy,
    output logic [DATA_W-1:0]         DataIn,
    output logic                      NewData,
    input  logic                      DoneTx
);

    localparam int unsigned OW     = $clog2(N_REQ);
    localparam int unsigned MAX_AB = (NEWDATA_CYCLES > GAP_CYCLES) ? NEWDATA_CYCLES : GAP_CYCLES;
    localparam int unsigned MAXC   = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int unsigned CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ND_LAST  = CW'(NEWDATA_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                nd_q, nd_d;
    logic                done_q;
    logic                done_rise;

    logic                found;
    logic [31:0]         scan_idx;
    logic [OW-1:0]       win_idx;
    logic [DATA_W-1:0]   win_data;

    assign done_rise = DoneTx & ~done_q;

    // Round-robin pick: first requester found scanning upward from the one
    // after the previous owner, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        win_idx  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = (32'(last_q) + k) % N_REQ;
            if (!found && Req[scan_idx]) begin
                found   = 1'b1;
                win_idx = OW'(scan_idx);
            end
        end
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (OW'(i) == win_idx) begin
                win_data = ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        data_d  = data_q;
        nd_d    = nd_q;
        case (state_q)
            IDLE: begin
                if (|Req) begin
                    owner_d          = win_idx;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    data_d           = win_data;
                    nd_d             = 1'b1;
                    cnt_d            = '0;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                // Any DoneTx edge here belongs to an earlier transfer.
                if (cnt_q == ND_LAST) begin
                    nd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + CNT_ONE;
                // A done edge arriving on the timeout clock still counts as success.
                if (done_rise) begin
                    ack_d[owner_q] = 1'b1;
                    gnt_d          = '0;
                    last_d         = owner_q;
                    cnt_d          = '0;
                    state_d        = GAP;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    last_d  = owner_q;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_Baudin) begin
        if (RstTx) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            last_q  <= OW'(N_REQ - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            nd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
            nd_q    <= nd_d;
            done_q  <= DoneTx;
        end
    end

    assign Gnt     = gnt_q;
    assign Ack     = ack_q;
    assign Err     = err_q;
    assign Busy    = (state_q != IDLE);
    assign DataIn  = data_q;
    assign NewData = nd_q;

endmodule
